// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared breakout geometry, pixel pipeline latency and ball state type.
package breakout_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        LOST      = 2'd2,
        GAME_OVER = 2'd3
    } ball_state_t;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 80;
    localparam int PADDLE_Y  = 440;

    // Cycles between a pixel coordinate and the matching brick_on sample.
    localparam int PIX_LAT   = 2;

endpackage

// File: rtl/ball_overlap_capture.sv
// rtl/ball_overlap_capture.sv - pixel delay line, ball-box test and first brick overlap latch per frame.
module ball_overlap_capture (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [8:0] pixel_y,
    input  logic       brick_on,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    input  logic       clear,
    input  logic       hold,
    output logic       ball_on,
    output logic       flag,
    output logic [9:0] hit_x,
    output logic [8:0] hit_y
);
    import breakout_pkg::*;

    logic [PIX_LAT-1:0][9:0] px_q;
    logic [PIX_LAT-1:0][8:0] py_q;
    logic [PIX_LAT-1:0]      in_q;
    logic                    flag_q;
    logic [9:0]              hit_x_q;
    logic [8:0]              hit_y_q;
    logic                    in_box;

    assign in_box = (pixel_x >= ball_x)
                 && ({1'b0, pixel_x} < {1'b0, ball_x} + 11'(BALL_SIZE))
                 && (pixel_y >= ball_y)
                 && ({1'b0, pixel_y} < {1'b0, ball_y} + 10'(BALL_SIZE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q    <= '0;
            py_q    <= '0;
            in_q    <= '0;
            flag_q  <= 1'b0;
            hit_x_q <= '0;
            hit_y_q <= '0;
        end else begin
            px_q[0] <= pixel_x;
            py_q[0] <= pixel_y;
            in_q[0] <= in_box;
            for (int i = 1; i < PIX_LAT; i++) begin
                px_q[i] <= px_q[i-1];
                py_q[i] <= py_q[i-1];
                in_q[i] <= in_q[i-1];
            end
            // hold keeps hit_x/hit_y stable while the hit pulse is being reported
            if (clear) begin
                flag_q <= 1'b0;
            end else if (in_q[PIX_LAT-1] && brick_on && !flag_q && !hold) begin
                flag_q  <= 1'b1;
                hit_x_q <= px_q[PIX_LAT-1];
                hit_y_q <= py_q[PIX_LAT-1];
            end
        end
    end

    assign ball_on = in_q[PIX_LAT-1];
    assign flag    = flag_q;
    assign hit_x   = hit_x_q;
    assign hit_y   = hit_y_q;

endmodule

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - breakout ball motion, bounces, brick hit reporting and lives/serve FSM.
// Optional BALL_SPEEDUP_EN: ball speeds up by one step every few brick hits.
module ball_controller #(
    parameter int SPEED       = 3,
    parameter int LIVES_INIT  = 3,
    parameter int LOST_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] pixel_x,
    input  logic [8:0] pixel_y,
    input  logic       brick_on,
    input  logic [9:0] paddle_x,
    input  logic       launch,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic       ball_on,
    output logic       ball_hit,
    output logic [9:0] hit_x,
    output logic [8:0] hit_y,
    output logic [1:0] lives,
    output logic       game_over
);
    import breakout_pkg::*;

    localparam int                LC_W       = $clog2(LOST_FRAMES);
    localparam logic signed [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]        X_MAX_U    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic signed [9:0] Y_LOST     = 10'(SCREEN_H);
    localparam logic signed [9:0] Y_PAD      = 10'(PADDLE_Y - BALL_SIZE);
    localparam logic [8:0]        SERVE_Y    = 9'(PADDLE_Y - BALL_SIZE);
    localparam logic [9:0]        CENTER_OFS = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]        RESET_X    = 10'((SCREEN_W - PADDLE_W) / 2) + CENTER_OFS;

    ball_state_t       state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              dxn_q, dxn_d;
    logic              dyn_q, dyn_d;
    logic [1:0]        lives_q, lives_d;
    logic [LC_W-1:0]   lost_cnt_q, lost_cnt_d;
    logic              launch_q;
    logic              ball_hit_q, ball_hit_d;
    logic              game_over_q, game_over_d;

    logic              flag;
    logic              launch_rise;
    logic [2:0]        spd;
    logic [3:0]        mag, vx, vy;
    logic signed [10:0] next_x;
    logic signed [9:0]  next_y;
    logic              x_overlap;
    logic              paddle_bounce;
    logic [9:0]        serve_x;

    ball_overlap_capture u_capture (
        .clk      (clk),
        .reset    (reset),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .brick_on (brick_on),
        .ball_x   (x_q),
        .ball_y   (y_q),
        .clear    (frame_tick),
        .hold     (ball_hit_q),
        .ball_on  (ball_on),
        .flag     (flag),
        .hit_x    (hit_x),
        .hit_y    (hit_y)
    );

`ifdef BALL_SPEEDUP_EN
    localparam int SPEEDUP_HITS = 4;
    localparam int MAX_SPEED    = 6;

    logic [2:0] spd_q, spd_d;
    logic [2:0] hits_q, hits_d;

    always_comb begin
        spd_d  = spd_q;
        hits_d = hits_q;
        if (state_q == SERVE && launch_rise) begin
            spd_d  = 3'(SPEED);
            hits_d = 3'd0;
        end else if (state_q == PLAY && frame_tick && flag) begin
            hits_d = hits_q + 3'd1;
            if (hits_q == 3'(SPEEDUP_HITS - 1)) begin
                hits_d = 3'd0;
                if (spd_q < 3'(MAX_SPEED)) begin
                    spd_d = spd_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spd_q  <= 3'(SPEED);
            hits_q <= 3'd0;
        end else begin
            spd_q  <= spd_d;
            hits_q <= hits_d;
        end
    end

    assign spd = spd_q;
`else
    assign spd = 3'(SPEED);
`endif

    // Velocity is kept as a shared magnitude plus one sign bit per axis.
    assign mag     = {1'b0, spd};
    assign vx      = dxn_q ? 4'd0 - mag : mag;
    assign vy      = dyn_q ? 4'd0 - mag : mag;
    assign next_x  = $signed({1'b0, x_q}) + $signed({{7{vx[3]}}, vx});
    assign next_y  = $signed({1'b0, y_q}) + $signed({{6{vy[3]}}, vy});
    assign serve_x = paddle_x + CENTER_OFS;
    assign launch_rise = launch && !launch_q;

    assign x_overlap = ({1'b0, x_q} + 11'(BALL_SIZE) > {1'b0, paddle_x})
                    && ({1'b0, x_q} < {1'b0, paddle_x} + 11'(PADDLE_W));
    assign paddle_bounce = !dyn_q && (next_y >= Y_PAD) && (y_q <= SERVE_Y) && x_overlap;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dxn_d       = dxn_q;
        dyn_d       = dyn_q;
        lives_d     = lives_q;
        lost_cnt_d  = lost_cnt_q;
        ball_hit_d  = 1'b0;
        case (state_q)
            SERVE: begin
                if (frame_tick) begin
                    x_d = serve_x;
                    y_d = SERVE_Y;
                end
                if (launch_rise) begin
                    state_d = PLAY;
                    dxn_d   = 1'b0;
                    dyn_d   = 1'b1;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    ball_hit_d = flag;
                    if (next_x[10]) begin
                        x_d   = 10'd0;
                        dxn_d = 1'b0;
                    end else if (next_x > X_MAX) begin
                        x_d   = X_MAX_U;
                        dxn_d = 1'b1;
                    end else begin
                        x_d = next_x[9:0];
                    end
                    // dy priority: paddle, then top wall, then brick
                    if (paddle_bounce) begin
                        y_d   = SERVE_Y;
                        dyn_d = 1'b1;
                    end else if (next_y[9]) begin
                        y_d   = 9'd0;
                        dyn_d = 1'b0;
                    end else begin
                        y_d = next_y[8:0];
                        if (flag) begin
                            dyn_d = !dyn_q;
                        end
                    end
                    if (next_y >= Y_LOST) begin
                        state_d    = LOST;
                        lives_d    = lives_q - 2'd1;
                        lost_cnt_d = '0;
                    end
                end
            end
            LOST: begin
                if (frame_tick) begin
                    if (lost_cnt_q == LC_W'(LOST_FRAMES - 1)) begin
                        lost_cnt_d = '0;
                        if (lives_q == 2'd0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d = SERVE;
                            x_d     = serve_x;
                            y_d     = SERVE_Y;
                        end
                    end else begin
                        lost_cnt_d = lost_cnt_q + LC_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SERVE;
            x_q         <= RESET_X;
            y_q         <= SERVE_Y;
            dxn_q       <= 1'b0;
            dyn_q       <= 1'b1;
            lives_q     <= 2'(LIVES_INIT);
            lost_cnt_q  <= '0;
            launch_q    <= 1'b0;
            ball_hit_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dxn_q       <= dxn_d;
            dyn_q       <= dyn_d;
            lives_q     <= lives_d;
            lost_cnt_q  <= lost_cnt_d;
            launch_q    <= launch;
            ball_hit_q  <= ball_hit_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign ball_hit  = ball_hit_q;
    assign lives     = lives_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - table-driven bench for ball_controller.
module tb_ball_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic [9:0] pixel_x;
    logic [8:0] pixel_y;
    logic       brick_on;
    logic [9:0] paddle_x;
    logic       launch;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic       ball_on;
    logic       ball_hit;
    logic [9:0] hit_x;
    logic [8:0] hit_y;
    logic [1:0] lives;
    logic       game_over;

    ball_controller dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .brick_on   (brick_on),
        .paddle_x   (paddle_x),
        .launch     (launch),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .ball_on    (ball_on),
        .ball_hit   (ball_hit),
        .hit_x      (hit_x),
        .hit_y      (hit_y),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pad;
        bit la;
        bit br;
        bit br2;
        int bx;
        int by;
        int ticks;
        int ex;
        int ey;
        int el;
        bit ego;
        bit ehit;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    task automatic do_launch();
        launch = 1'b1;
        @(negedge clk);
        launch = 1'b0;
        @(negedge clk);
    endtask

    // brick_on follows the pixel by two cycles; ball_on must line up with it
    task automatic inject(input int px, input int py, input string tag);
        pixel_x = 10'(px);
        pixel_y = 9'(py);
        @(negedge clk);
        pixel_x = '0;
        pixel_y = '0;
        @(negedge clk);
        brick_on = 1'b1;
        chk({tag, " ball_on"}, int'(ball_on), 1);
        @(negedge clk);
        brick_on = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        brick_on = 1'b0; paddle_x = 10'd280; launch = 1'b0;

        //            pad la br b2  bx   by tk   ex   ey el go hit
        vecs.push_back('{280, 0, 0, 0,   0,   0,  0, 316, 432, 3, 0, 0});
        vecs.push_back('{280, 0, 0, 0,   0,   0,  1, 316, 432, 3, 0, 0});
        vecs.push_back('{280, 1, 0, 0,   0,   0,  1, 319, 429, 3, 0, 0});
        vecs.push_back('{280, 0, 0, 0,   0,   0,  3, 328, 420, 3, 0, 0});
        vecs.push_back('{280, 0, 1, 1, 332, 424,  1, 331, 417, 3, 0, 1});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1, 334, 420, 3, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0, 19, 391, 477, 3, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1, 394, 480, 2, 0, 0});
        vecs.push_back('{  0, 1, 0, 0,   0,   0, 59, 394, 480, 2, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1,  36, 432, 2, 0, 0});
        vecs.push_back('{558, 0, 0, 0,   0,   0,  1, 594, 432, 2, 0, 0});
        vecs.push_back('{558, 1, 0, 0,   0,   0, 12, 630, 396, 2, 0, 0});
        vecs.push_back('{558, 0, 0, 0,   0,   0,  1, 632, 393, 2, 0, 0});
        vecs.push_back('{558, 0, 0, 0,   0,   0,  1, 629, 390, 2, 0, 0});
        vecs.push_back('{558, 0, 1, 0, 633, 394,  1, 626, 387, 2, 0, 1});
        vecs.push_back('{  0, 0, 0, 0,   0,   0, 30, 536, 477, 2, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1, 533, 480, 1, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0, 60,  36, 432, 1, 0, 0});
        vecs.push_back('{300, 0, 0, 0,   0,   0,  1, 336, 432, 1, 0, 0});
        vecs.push_back('{300, 1, 0, 0,   0,   0,  1, 339, 429, 1, 0, 0});
        vecs.push_back('{300, 0, 1, 0, 340, 430,  1, 342, 426, 1, 0, 1});
        vecs.push_back('{300, 0, 0, 0,   0,   0,  2, 348, 432, 1, 0, 0});
        vecs.push_back('{300, 0, 0, 0,   0,   0,  1, 351, 429, 1, 0, 0});
        vecs.push_back('{300, 0, 1, 0, 352, 430,  1, 354, 426, 1, 0, 1});
        vecs.push_back('{  0, 0, 0, 0,   0,   0, 17, 405, 477, 1, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1, 408, 480, 0, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0, 59, 408, 480, 0, 0, 0});
        vecs.push_back('{  0, 0, 0, 0,   0,   0,  1, 408, 480, 0, 1, 0});
        vecs.push_back('{  0, 1, 0, 0,   0,   0,  5, 408, 480, 0, 1, 0});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset hit_x", int'(hit_x), 0);
        chk("reset hit_y", int'(hit_y), 0);
        chk("reset ball_on", int'(ball_on), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            paddle_x = 10'(vecs[i].pad);
            if (vecs[i].la) do_launch();
            if (vecs[i].br) inject(vecs[i].bx, vecs[i].by, tag);
            if (vecs[i].br2) inject(vecs[i].bx + 1, vecs[i].by + 1, {tag, "b"});
            do_ticks(vecs[i].ticks);
            chk({tag, " ball_x"}, int'(ball_x), vecs[i].ex);
            chk({tag, " ball_y"}, int'(ball_y), vecs[i].ey);
            chk({tag, " lives"}, int'(lives), vecs[i].el);
            chk({tag, " game_over"}, int'(game_over), int'(vecs[i].ego));
            chk({tag, " ball_hit"}, int'(ball_hit), int'(vecs[i].ehit));
            if (vecs[i].ehit) begin
                chk({tag, " hit_x"}, int'(hit_x), vecs[i].bx);
                chk({tag, " hit_y"}, int'(hit_y), vecs[i].by);
                @(negedge clk);
                chk({tag, " ball_hit end"}, int'(ball_hit), 0);
                chk({tag, " hit_x held"}, int'(hit_x), vecs[i].bx);
            end
        end

        // asynchronous reset in PLAY with a brick overlap pending
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        paddle_x = 10'd100;
        @(negedge clk);
        do_ticks(1);
        chk("mr serve x", int'(ball_x), 136);
        do_launch();
        do_ticks(5);
        chk("mr play x", int'(ball_x), 151);
        chk("mr play y", int'(ball_y), 417);
        inject(152, 418, "mr");
        chk("mr pre hit_x", int'(hit_x), 152);
        #2;
        reset = 1'b1;
        #1;
        chk("mr ball_x", int'(ball_x), 316);
        chk("mr ball_y", int'(ball_y), 432);
        chk("mr lives", int'(lives), 3);
        chk("mr game_over", int'(game_over), 0);
        chk("mr hit_x", int'(hit_x), 0);
        chk("mr hit_y", int'(hit_y), 0);
        chk("mr ball_hit", int'(ball_hit), 0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        do_ticks(1);
        chk("mr post ball_hit", int'(ball_hit), 0);
        chk("mr post ball_x", int'(ball_x), 136);
        chk("mr post ball_y", int'(ball_y), 432);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
